// File: rtl/input_capture_unit.sv
// Board-input front end: synchronised, debounced buttons capture the switch bus into an FWFT FIFO.
// Build option INPUT_DEBOUNCE_EN enables the per-button debouncers; otherwise presses are sync rising edges.
module input_capture_unit #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [DATA_W-1:0]      input_signal,
  input  logic                   input_btn,
  input  logic                   output_btn,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic                   show_result,
  input  logic                   show_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
`ifdef INPUT_DEBOUNCE_EN
  localparam int ARM_N = SYNC_STAGES + DB_CYCLES;
`else
  localparam int ARM_N = SYNC_STAGES + 1 + 0 * DB_CYCLES;
`endif
  localparam int AW = $clog2(ARM_N + 1);

  logic [SYNC_STAGES-1:0] in_btn_sync;
  logic [SYNC_STAGES-1:0] out_btn_sync;
  logic [DATA_W-1:0]      sw_sync [SYNC_STAGES];
  logic [1:0]             btn_lvl;
  logic [DATA_W-1:0]      sw_lvl;
  logic [1:0]             press;
  logic [DATA_W-1:0]      push_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_btn_sync  <= '0;
      out_btn_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      in_btn_sync  <= {in_btn_sync[SYNC_STAGES-2:0], input_btn};
      out_btn_sync <= {out_btn_sync[SYNC_STAGES-2:0], output_btn};
      sw_sync[0]   <= input_signal;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  assign btn_lvl = {out_btn_sync[SYNC_STAGES-1], in_btn_sync[SYNC_STAGES-1]};
  assign sw_lvl  = sw_sync[SYNC_STAGES-1];

  // A button held through reset must not count as a press: presses are ignored until the
  // synchronised level has been seen low for longer than the synchroniser's reset zeros last.
  logic [1:0]    armed;
  logic [AW-1:0] arm_cnt [2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed <= '0;
      for (int b = 0; b < 2; b++) arm_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!armed[b]) begin
          if (btn_lvl[b])
            arm_cnt[b] <= '0;
          else if (arm_cnt[b] == AW'(ARM_N - 1))
            armed[b] <= 1'b1;
          else
            arm_cnt[b] <= arm_cnt[b] + AW'(1);
        end
      end
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] ST_WAIT_H = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_WAIT_L = 2'd3;

  logic [1:0]    db_state [2];
  logic [CW-1:0] db_cnt   [2];
  logic [1:0]    db_done;

  always_comb begin
    db_done = '0;
    press   = '0;
    for (int b = 0; b < 2; b++) begin
      db_done[b] = (db_cnt[b] == CW'(DB_CYCLES - 1));
      press[b]   = (db_state[b] == ST_WAIT_H) && btn_lvl[b] && db_done[b] && armed[b];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int b = 0; b < 2; b++) begin
        db_state[b] <= ST_LOW;
        db_cnt[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        case (db_state[b])
          ST_LOW: begin
            if (btn_lvl[b]) begin
              db_state[b] <= ST_WAIT_H;
              db_cnt[b]   <= '0;
            end
          end
          ST_WAIT_H: begin
            if (!btn_lvl[b]) begin
              db_state[b] <= ST_LOW;
              db_cnt[b]   <= '0;
            end else if (db_done[b]) begin
              db_state[b] <= ST_HIGH;
              db_cnt[b]   <= '0;
            end else begin
              db_cnt[b] <= db_cnt[b] + CW'(1);
            end
          end
          ST_HIGH: begin
            if (!btn_lvl[b]) begin
              db_state[b] <= ST_WAIT_L;
              db_cnt[b]   <= '0;
            end
          end
          default: begin
            if (btn_lvl[b]) begin
              db_state[b] <= ST_HIGH;
              db_cnt[b]   <= '0;
            end else if (db_done[b]) begin
              db_state[b] <= ST_LOW;
              db_cnt[b]   <= '0;
            end else begin
              db_cnt[b] <= db_cnt[b] + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign push_data = sw_lvl;
`else
  logic [1:0]        lvl_prev;
  logic [1:0]        press_p0;
  logic [DATA_W-1:0] sw_p0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl_prev <= '0;
      press_p0 <= '0;
    end else begin
      lvl_prev <= btn_lvl;
      press_p0 <= btn_lvl & ~lvl_prev & armed;
    end
  end

  always_ff @(posedge CLK) sw_p0 <= sw_lvl;

  assign press     = press_p0;
  assign push_data = sw_p0;
`endif

  // FIFO: head_q mirrors the entry at rd_ptr so the head is visible without a read cycle.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     next_rd;
  logic [LW-1:0]     count;
  logic [DATA_W-1:0] head_q;
  logic              do_pop;
  logic              do_push;

  assign next_rd = rd_ptr + PW'(1);
  assign do_pop  = rd_en && (count != '0);
  assign do_push = press[0] && ((count != LW'(DEPTH)) || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_q      <= '0;
      overflow    <= 1'b0;
      show_result <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= next_rd;
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (press[0] && !do_push) overflow <= 1'b1;
      if (do_push && ((count == '0) || (do_pop && (count == LW'(1)))))
        head_q <= push_data;
      else if (do_pop && (count > LW'(1)))
        head_q <= mem[next_rd];
      if (press[1])
        show_result <= 1'b1;
      else if (show_clr)
        show_result <= 1'b0;
    end
  end

  assign rd_data    = head_q;
  assign rd_valid   = (count != '0);
  assign fill_level = count;

endmodule

// File: tb/tb_input_capture_unit.sv
// Directed bench for input_capture_unit: capture latency, bounce, FIFO fill/overflow, push+pop, show flag.
module tb_input_capture_unit;
  localparam int DATA_W      = 4;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;
`ifdef INPUT_DEBOUNCE_EN
  localparam int LAT      = SYNC_STAGES + DB_CYCLES;
  localparam int BOUNCE_N = 1;
`else
  localparam int LAT      = SYNC_STAGES + 1;
  localparam int BOUNCE_N = 3;
`endif
  localparam int HOLD = 10;
  localparam int GAP  = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] input_signal;
  logic              input_btn;
  logic              output_btn;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [2:0]        fill_level;
  logic              overflow;
  logic              show_result;
  logic              show_clr;

  int checks = 0;
  int errors = 0;

  input_capture_unit #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .input_signal(input_signal), .input_btn(input_btn),
    .output_btn(output_btn), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fill_level(fill_level), .overflow(overflow), .show_result(show_result), .show_clr(show_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input logic [DATA_W-1:0] v);
    input_signal = v;
    input_btn    = 1'b1;
    step(HOLD);
    input_btn = 1'b0;
    step(GAP);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(GAP);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; input_btn = 1'b1; input_signal = 4'h5;
    step(3);
    checks++;
    if (rd_valid !== 1'b0 || fill_level !== 3'd0 || rd_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_fifo: rd_data=%h rd_valid=%b fill=%0d, required 0/0/0", rd_data, rd_valid, fill_level);
    end
    checks++;
    if (overflow !== 1'b0 || show_result !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: overflow=%b show_result=%b, required 0/0", overflow, show_result);
    end
    rst_n = 1'b1;
    step(20);
    checks++;
    if (fill_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_held_no_push: fill=%0d, required 0", fill_level);
    end
    input_btn = 1'b0;
    step(GAP);
    checks++;
    if (fill_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_no_push: fill=%0d, required 0", fill_level);
    end
  endtask

  task automatic test_clean_press();
    input_signal = 4'hA; input_btn = 1'b1;
    step(LAT);
    checks++;
    if (fill_level !== 3'd0) begin
      errors++;
      $display("FAIL clean_early: fill=%0d one cycle before push, required 0", fill_level);
    end
    step(1);
    checks++;
    if (fill_level !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 4'hA) begin
      errors++;
      $display("FAIL clean_push: fill=%0d rd_valid=%b rd_data=%h, required 1/1/a", fill_level, rd_valid, rd_data);
    end
    step(HOLD - LAT - 1);
    input_btn = 1'b0;
    step(GAP);
    checks++;
    if (fill_level !== 3'd1) begin
      errors++;
      $display("FAIL clean_single: fill=%0d after hold and release, required 1", fill_level);
    end
    pop_one();
    checks++;
    if (rd_valid !== 1'b0 || fill_level !== 3'd0 || rd_data !== 4'hA) begin
      errors++;
      $display("FAIL clean_pop: rd_valid=%b fill=%0d rd_data=%h, required 0/0/a", rd_valid, fill_level, rd_data);
    end
  endtask

  task automatic test_bounce();
    input_signal = 4'h6;
    input_btn = 1'b1; step(1);
    input_btn = 1'b0; step(1);
    input_btn = 1'b1; step(1);
    input_btn = 1'b0; step(1);
    input_btn = 1'b1;
    step(LAT);
    checks++;
    if (fill_level !== 3'(BOUNCE_N - 1)) begin
      errors++;
      $display("FAIL bounce_early: fill=%0d, required %0d", fill_level, BOUNCE_N - 1);
    end
    step(1);
    checks++;
    if (fill_level !== 3'(BOUNCE_N)) begin
      errors++;
      $display("FAIL bounce_push: fill=%0d, required %0d", fill_level, BOUNCE_N);
    end
    step(HOLD - LAT - 1);
    input_btn = 1'b0;
    step(GAP);
    checks++;
    if (fill_level !== 3'(BOUNCE_N)) begin
      errors++;
      $display("FAIL bounce_count: fill=%0d, required %0d", fill_level, BOUNCE_N);
    end
    for (int i = 0; i < BOUNCE_N; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'h6) begin
        errors++;
        $display("FAIL bounce_data[%0d]: rd_valid=%b rd_data=%h, required 1/6", i, rd_valid, rd_data);
      end
      pop_one();
    end
  endtask

  task automatic test_fill_overflow();
    for (int v = 1; v <= 5; v++) press_btn(4'(v));
    checks++;
    if (fill_level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: fill=%0d overflow=%b, required 4/1", fill_level, overflow);
    end
    for (int v = 1; v <= 4; v++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'(v)) begin
        errors++;
        $display("FAIL overflow_pop[%0d]: rd_valid=%b rd_data=%h, required 1/%h", v, rd_valid, rd_data, 4'(v));
      end
      pop_one();
    end
    checks++;
    if (rd_valid !== 1'b0 || fill_level !== 3'd0 || rd_data !== 4'h4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained: rd_valid=%b fill=%0d rd_data=%h overflow=%b, required 0/0/4/1",
               rd_valid, fill_level, rd_data, overflow);
    end
    pop_one();
    checks++;
    if (rd_valid !== 1'b0 || fill_level !== 3'd0) begin
      errors++;
      $display("FAIL pop_empty: rd_valid=%b fill=%0d, required 0/0", rd_valid, fill_level);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] exp_q [4];
    exp_q[0] = 4'h2; exp_q[1] = 4'h3; exp_q[2] = 4'h4; exp_q[3] = 4'h9;
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reset: overflow=%b, required 0", overflow);
    end
    for (int v = 1; v <= 4; v++) press_btn(4'(v));
    input_signal = 4'h9; input_btn = 1'b1;
    step(LAT);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (overflow !== 1'b0 || fill_level !== 3'd4 || rd_data !== 4'h2) begin
      errors++;
      $display("FAIL full_push_pop: overflow=%b fill=%0d rd_data=%h, required 0/4/2", overflow, fill_level, rd_data);
    end
    step(HOLD - LAT - 1);
    input_btn = 1'b0;
    step(GAP);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin
        errors++;
        $display("FAIL full_drain[%0d]: rd_valid=%b rd_data=%h, required 1/%h", i, rd_valid, rd_data, exp_q[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_back_to_back();
    press_btn(4'h7);
    input_signal = 4'h8; input_btn = 1'b1;
    step(LAT);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (fill_level !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 4'h8) begin
      errors++;
      $display("FAIL one_entry_push_pop: fill=%0d rd_valid=%b rd_data=%h, required 1/1/8", fill_level, rd_valid, rd_data);
    end
    step(HOLD - LAT - 1);
    input_btn = 1'b0;
    step(GAP);
    pop_one();
    checks++;
    if (fill_level !== 3'd0) begin
      errors++;
      $display("FAIL one_entry_drain: fill=%0d, required 0", fill_level);
    end
  endtask

  task automatic test_show();
    output_btn = 1'b1;
    step(LAT);
    checks++;
    if (show_result !== 1'b0) begin
      errors++;
      $display("FAIL show_early: show_result=%b, required 0", show_result);
    end
    step(1);
    checks++;
    if (show_result !== 1'b1) begin
      errors++;
      $display("FAIL show_set: show_result=%b, required 1", show_result);
    end
    step(HOLD - LAT - 1);
    output_btn = 1'b0;
    step(GAP);
    show_clr = 1'b1;
    step(1);
    show_clr = 1'b0;
    checks++;
    if (show_result !== 1'b0) begin
      errors++;
      $display("FAIL show_clear: show_result=%b, required 0", show_result);
    end
    output_btn = 1'b1;
    step(LAT);
    show_clr = 1'b1;
    step(1);
    show_clr = 1'b0;
    checks++;
    if (show_result !== 1'b1) begin
      errors++;
      $display("FAIL show_set_wins: show_result=%b, required 1", show_result);
    end
    show_clr = 1'b1;
    step(1);
    show_clr = 1'b0;
    step(3);
    checks++;
    if (show_result !== 1'b0) begin
      errors++;
      $display("FAIL show_hold_once: show_result=%b while held, required 0", show_result);
    end
    output_btn = 1'b0;
    step(GAP);
    checks++;
    if (fill_level !== 3'd0) begin
      errors++;
      $display("FAIL show_no_capture: fill=%0d, required 0", fill_level);
    end
  endtask

  task automatic test_async_reset();
    press_btn(4'h3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fill_level !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: fill=%0d rd_valid=%b rd_data=%h, required 0/0/0", fill_level, rd_valid, rd_data);
    end
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    rst_n = 1'b0; input_signal = '0; input_btn = 1'b0; output_btn = 1'b0;
    rd_en = 1'b0; show_clr = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_show();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
